// File: rtl/cnn_conv_engine.sv
// Tiled fixed-point convolution engine for one CNN layer.
// The sequencer fills the feature-map and weight buffers while idle, pulses
// start_i, and collects M_p*RO*CO results from a valid/ready stream. Each MAC
// cycle evaluates Tm_p output channels times Tn_p input channels for one
// kernel tap; each output tile is drained one channel per handshake.
module cnn_conv_engine #(
    parameter int N_p    = 4,
    parameter int M_p    = 4,
    parameter int K_p    = 3,
    parameter int R_p    = 8,
    parameter int C_p    = 8,
    parameter int S_p    = 1,
    parameter int Tn_p   = 2,
    parameter int Tm_p   = 2,
    parameter int DW_p   = 16,
    parameter int FRAC_p = 8
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      start_i,
    input  logic                                      relu_en_i,
    input  logic                                      fm_we_i,
    input  logic [$clog2(N_p*R_p*C_p)-1:0]            fm_addr_i,
    input  logic signed [DW_p-1:0]                    fm_data_i,
    input  logic                                      wt_we_i,
    input  logic [$clog2(M_p*N_p*K_p*K_p)-1:0]        wt_addr_i,
    input  logic signed [DW_p-1:0]                    wt_data_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic signed [DW_p-1:0]                    out_data_o,
    output logic [$clog2(M_p)-1:0]                    out_ch_o,
    output logic [$clog2((R_p-K_p)/S_p+1)-1:0]        out_row_o,
    output logic [$clog2((C_p-K_p)/S_p+1)-1:0]        out_col_o
);

    localparam int RO       = (R_p - K_p) / S_p + 1;
    localparam int CO       = (C_p - K_p) / S_p + 1;
    localparam int ACC_W    = 2*DW_p + $clog2(N_p*K_p*K_p);
    localparam int FM_DEPTH = N_p*R_p*C_p;
    localparam int WT_DEPTH = M_p*N_p*K_p*K_p;
    localparam int FA_W     = $clog2(FM_DEPTH);
    localparam int WA_W     = $clog2(WT_DEPTH);
    localparam int CH_W     = $clog2(M_p);
    localparam int RO_W     = $clog2(RO);
    localparam int CO_W     = $clog2(CO);
    localparam int NI_W     = (N_p  > 1) ? $clog2(N_p)  : 1;
    localparam int K_W      = (K_p  > 1) ? $clog2(K_p)  : 1;
    localparam int Z_W      = (Tm_p > 1) ? $clog2(Tm_p) : 1;

    localparam logic [FA_W:0]   FM_DEPTH_C = (FA_W+1)'(FM_DEPTH);
    localparam logic [WA_W:0]   WT_DEPTH_C = (WA_W+1)'(WT_DEPTH);
    localparam logic [NI_W-1:0] TI_LAST    = NI_W'(N_p - Tn_p);
    localparam logic [NI_W-1:0] TN_STEP    = NI_W'(Tn_p);
    localparam logic [K_W-1:0]  K_LAST     = K_W'(K_p - 1);
    localparam logic [CH_W-1:0] TO_LAST    = CH_W'(M_p - Tm_p);
    localparam logic [CH_W-1:0] TM_STEP    = CH_W'(Tm_p);
    localparam logic [RO_W-1:0] ROW_LAST   = RO_W'(RO - 1);
    localparam logic [CO_W-1:0] COL_LAST   = CO_W'(CO - 1);
    localparam logic [Z_W-1:0]  Z_LAST     = Z_W'(Tm_p - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW_p+1){1'b0}}, {(DW_p-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW_p+1){1'b1}}, {(DW_p-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_DONE} state_t;

    state_t state_q, state_d;

    logic signed [DW_p-1:0]  fm_mem [FM_DEPTH];
    logic signed [DW_p-1:0]  wt_mem [WT_DEPTH];

    logic signed [ACC_W-1:0] acc_p0  [Tm_p];
    logic signed [ACC_W-1:0] acc_nxt [Tm_p];
    logic signed [DW_p-1:0]  out_data_p1;

    logic [CH_W-1:0] to_q;
    logic [RO_W-1:0] row_q;
    logic [CO_W-1:0] col_q;
    logic [NI_W-1:0] ti_q;
    logic [K_W-1:0]  i_q;
    logic [K_W-1:0]  j_q;
    logic [Z_W-1:0]  z_q;
    logic            relu_q;

    logic [FA_W-1:0]          fa;
    logic [WA_W-1:0]          wa;
    logic signed [2*DW_p-1:0] prod;

    logic mac_last;
    logic tile_last;
    logic hs;

    // Shift the accumulator back to Q format (floor) and clamp to DW_p bits.
    function automatic logic signed [DW_p-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC_p;
        if (sh > SAT_MAX)
            return SAT_MAX[DW_p-1:0];
        else if (sh < SAT_MIN)
            return SAT_MIN[DW_p-1:0];
        else
            return sh[DW_p-1:0];
    endfunction

    // Optional rectification, applied to the already saturated value.
    function automatic logic signed [DW_p-1:0] relu_fn(input logic signed [DW_p-1:0] v,
                                                       input logic en);
        return (en && v[DW_p-1]) ? '0 : v;
    endfunction

    assign mac_last  = (ti_q == TI_LAST) && (i_q == K_LAST) && (j_q == K_LAST);
    assign tile_last = (to_q == TO_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign hs        = out_valid_o && out_ready_i;

    assign out_data_o = out_data_p1;
    assign out_ch_o   = to_q + CH_W'(z_q);
    assign out_row_o  = row_q;
    assign out_col_o  = col_q;

    // Buffer writes are only honoured while idle and in range.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_IDLE && fm_we_i && ({1'b0, fm_addr_i} < FM_DEPTH_C))
            fm_mem[fm_addr_i] <= fm_data_i;
        if (state_q == ST_IDLE && wt_we_i && ({1'b0, wt_addr_i} < WT_DEPTH_C))
            wt_mem[wt_addr_i] <= wt_data_i;
    end

    // One kernel tap for Tm_p output x Tn_p input channels, added to the accumulators.
    always_comb begin
        fa   = '0;
        wa   = '0;
        prod = '0;
        for (int z = 0; z < Tm_p; z++) begin
            acc_nxt[z] = acc_p0[z];
            for (int t = 0; t < Tn_p; t++) begin
                fa = FA_W'(((int'(ti_q) + t)*R_p + int'(row_q)*S_p + int'(i_q))*C_p
                           + int'(col_q)*S_p + int'(j_q));
                wa = WA_W'((((int'(to_q) + z)*N_p + int'(ti_q) + t)*K_p + int'(i_q))*K_p
                           + int'(j_q));
                prod = fm_mem[fa] * wt_mem[wa];
                acc_nxt[z] = acc_nxt[z] + ACC_W'(prod);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and status decode.
    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i)
                    state_d = ST_MAC;
            end
            ST_MAC: begin
                busy_o = 1'b1;
                if (mac_last)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (hs && z_q == Z_LAST)
                    state_d = tile_last ? ST_DONE : ST_MAC;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Loop counters, accumulators and the registered output value.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            to_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ti_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            z_q         <= '0;
            relu_q      <= 1'b0;
            acc_p0      <= '{default: '0};
            out_data_p1 <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        relu_q <= relu_en_i;
                        to_q   <= '0;
                        row_q  <= '0;
                        col_q  <= '0;
                        ti_q   <= '0;
                        i_q    <= '0;
                        j_q    <= '0;
                        z_q    <= '0;
                        acc_p0 <= '{default: '0};
                    end
                end
                ST_MAC: begin
                    acc_p0 <= acc_nxt;
                    if (j_q == K_LAST) begin
                        j_q <= '0;
                        if (i_q == K_LAST) begin
                            i_q  <= '0;
                            ti_q <= (ti_q == TI_LAST) ? '0 : ti_q + TN_STEP;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if (mac_last)
                        out_data_p1 <= relu_fn(sat_fn(acc_nxt[0]), relu_q);
                end
                ST_DRAIN: begin
                    if (hs) begin
                        if (z_q == Z_LAST) begin
                            z_q    <= '0;
                            acc_p0 <= '{default: '0};
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                if (row_q == ROW_LAST) begin
                                    row_q <= '0;
                                    to_q  <= (to_q == TO_LAST) ? '0 : to_q + TM_STEP;
                                end else begin
                                    row_q <= row_q + 1'b1;
                                end
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end else begin
                            z_q         <= z_q + 1'b1;
                            out_data_p1 <= relu_fn(sat_fn(acc_p0[Z_W'(z_q + 1'b1)]), relu_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cnn_conv_engine.md
Name: cnn_conv_engine

Overview:
- Parametrised, synthesizable successor to the single-layer CNN block: fixed-point instead of shortreal, configurable stride, full Tn/Tm tiling over all input/output channels, optional ReLU.
- Load inputs into internal buffers, pulse start, then read results from a valid/ready stream.
- Sits between the layer-level sequencer, which loads buffers, and the output writeback.

Parameters:
- N_p, 4: input channels; must be a multiple of Tn_p.
- M_p, 4: output channels; must be a multiple of Tm_p.
- K_p, 3: kernel size (K_p x K_p).
- R_p, 8: input rows.
- C_p, 8: input columns.
- S_p, 1: stride.
- Tn_p, 2: input channels per MAC cycle.
- Tm_p, 2: output channels per tile.
- DW_p, 16: signed data width.
- FRAC_p, 8: fractional bits (Q format).
- Derived: RO = (R_p-K_p)/S_p+1, CO = (C_p-K_p)/S_p+1, ACC_W = 2*DW_p + clog2(N_p*K_p*K_p).

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: reset, asynchronous, active-high.
- start_i, in, 1: begin layer; sampled only in IDLE.
- relu_en_i, in, 1: ReLU enable; latched at start.
- fm_we_i, in, 1: input feature-map buffer write enable.
- fm_addr_i, in, clog2(N_p*R_p*C_p): address, (n*R_p+r)*C_p+c.
- fm_data_i, in, DW_p: signed feature value.
- wt_we_i, in, 1: weight buffer write enable.
- wt_addr_i, in, clog2(M_p*N_p*K_p*K_p): address, ((m*N_p+n)*K_p+i)*K_p+j.
- wt_data_i, in, DW_p: signed weight.
- busy_o, out, 1: high from the cycle after an accepted start until done_o.
- done_o, out, 1: one-cycle pulse after the final output handshake.
- out_valid_o, out, 1: output stream valid.
- out_ready_i, in, 1: output stream ready.
- out_data_o, out, DW_p: output value.
- out_ch_o, out, clog2(M_p): output channel tag.
- out_row_o, out, clog2(RO): output row tag.
- out_col_o, out, clog2(CO): output column tag.

Behaviour:
- Reset (async assert):
  - State = IDLE.
  - Outputs: busy_o, done_o, out_valid_o = 0; out_data_o and all tags = 0.
  - Accumulators and all counters = 0.
  - Buffer arrays are not reset; their contents are undefined until written.
- Buffer writes:
  - Accepted only in IDLE. Writes in any other state, or to out-of-range addresses, are dropped.
  - One write per port per cycle.
  - A write and start_i in the same cycle: the write lands first, so the computation sees it.
- State machine:
  - IDLE -> MAC on start_i. Latch relu_en_i, clear to/row/col/ti/i/j counters, clear the Tm_p accumulators.
  - MAC: one (ti,i,j) step per cycle. For each z < Tm_p: acc[z] += sum over t < Tn_p of wt[to+z][ti+t][i][j] * fm[ti+t][row*S_p+i][col*S_p+j].
  - Loop order in MAC: j fastest, then i, then ti (step Tn_p). After (N_p/Tn_p)*K_p*K_p cycles -> DRAIN.
  - DRAIN: present channel to+z for z = 0..Tm_p-1, one per handshake.
  - On the last handshake of a tile: advance col, then row, then to (step Tm_p). Clear accumulators; return to MAC, or -> DONE after the final tile.
  - DONE: done_o = 1 for one cycle, busy_o drops in the same cycle, -> IDLE.
  - start_i outside IDLE is ignored.
- Output stream:
  - out_valid_o asserts registered, on the cycle after MAC completes.
  - Data and tags stay stable while out_valid_o=1 and out_ready_i=0.
  - A transfer occurs when valid && ready. The next element appears in the following cycle with no bubble.
  - Total transfers per layer = M_p*RO*CO.
  - Order: to outermost, then row, then col, then z.
- Arithmetic:
  - Products are full 2*DW_p width; accumulation at ACC_W, with no overflow possible.
  - Output = acc >>> FRAC_p (arithmetic shift, truncation toward -inf), then saturate to [-2^(DW_p-1), 2^(DW_p-1)-1].
  - When relu_en is set, negative results become 0, applied after saturation.
- Latency per tile = (N_p/Tn_p)*K_p*K_p MAC cycles + Tm_p handshakes.
- Reset mid-operation: immediate return to IDLE with no done_o pulse. Any pending output is discarded.

Test Plan:
- Config N=M=2, K=2, R=C=4, S=1, Tn=Tm=1, FRAC=8; all fm=256 (1.0), all wt=256 -> 18 outputs, each 2048 (8.0). Tags in order ch0 (0,0)..(2,2), then ch1. done_o pulses once.
- Same data with S=2 -> RO=CO=2, 8 outputs each 2048; tag sequence (0,0),(0,1),(1,0),(1,1) per channel.
- All wt=-256 -> outputs -2048 with relu_en=0, and 0 with relu_en=1. fm=25600 (100.0), wt=256 -> saturates to 32767.
- Backpressure: hold out_ready_i=0 for 5 cycles on the first element -> out_valid_o stays 1 and data/tags stay stable. Toggle ready every cycle -> exactly 18 transfers, no duplicates.
- start_i pulsed while busy, plus an fm write while busy -> ignored, results unchanged. Write fm[0] and start in the same cycle -> new value used.
- Assert reset_i mid-MAC -> busy_o and out_valid_o drop immediately with no done_o. Then reload the buffers and restart -> correct full result set.
